// File: rtl/data_mem_pipe.sv
// Pipelined MEM-stage data memory: valid/ready request and response, RD_LAT-deep
// in-order response pipeline, byte/half/word access with extension and fault counting.
module data_mem_pipe #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_op,
  input  logic             req_sext,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_wr,
  output logic             rsp_err,
  output logic [31:0]      rsp_rdata,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  // 33 bits so the mapped span still compares correctly at the 4 GiB extreme
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  typedef struct packed {
    logic        vld;
    logic        wr;
    logic        err;
    logic [31:0] data;
  } stage_t;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             fault;
  logic             stall;
  logic             accept;
  logic [31:0]      rd_word;
  stage_t           stage_p0;
  stage_t [RD_LAT:1] stage_p;

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] op,
                                               input logic [1:0] ln, input logic sext);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {ln, 3'b000};
    case (op)
      2'b00:   r = {{24{sext & sh[7]}}, sh[7:0]};
      2'b01:   r = {{16{sext & sh[15]}}, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] op, input logic [1:0] ln);
    logic [31:0] mask;
    logic [31:0] data;
    case (op)
      2'b00: begin
        mask = 32'h0000_00FF << {ln, 3'b000};
        data = {24'b0, wdata[7:0]} << {ln, 3'b000};
      end
      2'b01: begin
        mask = 32'h0000_FFFF << {ln, 3'b000};
        data = {16'b0, wdata[15:0]} << {ln, 3'b000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wdata;
      end
    endcase
    return (old & ~mask) | (data & mask);
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + ERR_W'(1);
  endfunction

  assign off       = req_addr - BASE_ADDR;
  assign idx       = off[2 +: IDX_W];
  assign lane      = off[1:0];
  assign fault     = (req_op == 2'b11) || ({1'b0, off} >= SPAN) ||
                     (req_op == 2'b01 && lane[0]) || (req_op == 2'b10 && lane != 2'b00);
  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = !rst && !stall;
  assign accept    = req_valid && req_ready;
  assign rd_word   = mem[idx];

  // Stores commit on the acceptance edge, so any later load already sees them
  always_ff @(posedge clk) begin
    if (accept && req_we && !fault)
      mem[idx] <= merge_store(rd_word, req_wdata, req_op, lane);
  end

  // Stage 0: request decode, lane select and extension
  always_comb begin
    stage_p0      = '0;
    stage_p0.vld  = accept;
    stage_p0.wr   = accept & req_we;
    stage_p0.err  = accept & fault;
    if (accept && !req_we && !fault)
      stage_p0.data = load_extract(rd_word, req_op, lane, req_sext);
  end

  // Stages 1..RD_LAT: lock-step delay line, frozen while the output is stalled
  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (rst)         stage_p <= '0;
      else if (!stall) stage_p <= stage_p0;
    end
  end else begin : g_latn
    always_ff @(posedge clk) begin
      if (rst)         stage_p <= '0;
      else if (!stall) stage_p <= {stage_p[RD_LAT-1:1], stage_p0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                 err_count <= '0;
    else if (accept && fault) err_count <= sat_inc(err_count);
  end

  assign rsp_valid = stage_p[RD_LAT].vld;
  assign rsp_wr    = stage_p[RD_LAT].wr;
  assign rsp_err   = stage_p[RD_LAT].err;
  assign rsp_rdata = stage_p[RD_LAT].data;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Bench for data_mem_pipe: two instances (RD_LAT=1 narrow counter, RD_LAT=3 wide counter),
// directed scenario tasks plus randomized traffic against a byte-array reference model.
module tb_data_mem_pipe;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  typedef struct {
    int          due;
    logic        wr;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       req_valid, req_ready, req_we, req_sext;
  logic [1:0]       rsp_valid, rsp_ready, rsp_wr, rsp_err;
  logic [1:0][1:0]  req_op;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]       err_a;
  logic [15:0]      err_b;

  logic [7:0] mb [DEPTH*4];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_pipe #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_LAT(1), .ERR_W(4)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_op(req_op[0]), .req_sext(req_sext[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_wr(rsp_wr[0]), .rsp_err(rsp_err[0]), .rsp_rdata(rsp_rdata[0]), .err_count(err_a));

  data_mem_pipe #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_LAT(3), .ERR_W(16)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_op(req_op[1]), .req_sext(req_sext[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_wr(rsp_wr[1]), .rsp_err(rsp_err[1]), .rsp_rdata(rsp_rdata[1]), .err_count(err_b));

  function automatic int lat(input int d);
    return (d != 0) ? 3 : 1;
  endfunction

  function automatic logic [15:0] errc(input int d);
    return (d != 0) ? err_b : {12'b0, err_a};
  endfunction

  function automatic logic model_fault(input logic [1:0] op, input logic [31:0] off);
    return (op == 2'b11) || (off >= 32'(DEPTH * 4)) ||
           (op == 2'b01 && off % 2 != 0) || (op == 2'b10 && off % 4 != 0);
  endfunction

  function automatic logic [31:0] model_load(input int off, input logic [1:0] op, input logic sext);
    longint v = 0;
    int n = 1 << op;
    for (int k = 0; k < n; k++) v += longint'(mb[off + k]) << (8 * k);
    if (sext && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  function automatic void model_store(input int off, input logic [1:0] op, input logic [31:0] wd);
    int n = 1 << op;
    for (int k = 0; k < n; k++) mb[off + k] = 8'((wd >> (8 * k)) & 32'hFF);
  endfunction

  task automatic do_req(input int d, input logic we, input logic [1:0] op, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bit ok = 0;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_op[d] = op; req_sext[d] = sext;
    req_addr[d] = addr; req_wdata[d] = wdata;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready[d]) begin ok = 1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL req_accept dut=%0d addr=%h: req_ready stayed 0, expected 1", d, addr);
    end else begin
      @(posedge clk);
    end
    #1 req_valid[d] = 1'b0;
  endtask

  task automatic get_rsp(input int d, output logic wr, output logic err,
                         output logic [31:0] data, output int cycles);
    cycles = 0; wr = 1'b0; err = 1'b0; data = '0;
    rsp_ready[d] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); #1;
      if (rsp_valid[d]) begin
        cycles = i; wr = rsp_wr[d]; err = rsp_err[d]; data = rsp_rdata[d];
        @(posedge clk);
        break;
      end
    end
    n_tests++;
    if (cycles == 0) begin
      n_fail++;
      $display("FAIL rsp_timeout dut=%0d: rsp_valid stayed 0, expected 1", d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b0 || rsp_wr[d] !== 1'b0 ||
          rsp_err[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || errc(d) !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_state dut=%0d: vld=%b rdy=%b wr=%b err=%b rdata=%h cnt=%0d, expected all 0",
                 d, rsp_valid[d], req_ready[d], rsp_wr[d], rsp_err[d], rsp_rdata[d], errc(d));
      end
    end
    @(negedge clk); rst = 1'b0; #1;
    n_tests++;
    if (req_ready !== 2'b11) begin
      n_fail++; $display("FAIL ready_after_reset: req_ready=%b, expected 11", req_ready);
    end
  endtask

  task automatic test_word_a();
    logic wr, err; logic [31:0] d; int c;
    do_req(0, 1'b1, 2'b10, 1'b0, BASE + 32'd8, 32'hDEAD_BEEF);
    get_rsp(0, wr, err, d, c);
    n_tests++;
    if (wr !== 1'b1 || err !== 1'b0 || d !== 32'h0) begin
      n_fail++; $display("FAIL store_word_rsp: wr=%b err=%b rdata=%h, expected 1 0 00000000", wr, err, d);
    end
    do_req(0, 1'b0, 2'b10, 1'b0, BASE + 32'd8, 32'h0);
    get_rsp(0, wr, err, d, c);
    n_tests++;
    if (wr !== 1'b0 || err !== 1'b0 || d !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL load_word: wr=%b err=%b rdata=%h, expected 0 0 deadbeef", wr, err, d);
    end
    n_tests++;
    if (c !== 1) begin
      n_fail++; $display("FAIL load_latency_1: got %0d cycles, expected 1", c);
    end
  endtask

  task automatic test_byte_a();
    logic wr, err; logic [31:0] d; int c;
    logic [31:0] t_off [6] = '{32'd9, 32'd9, 32'd8, 32'd10, 32'd8, 32'd11};
    logic [1:0]  t_op  [6] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00};
    logic        t_sx  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] t_exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h1122_8044,
                               32'h0000_1122, 32'hFFFF_8044, 32'h0000_0011};
    do_req(0, 1'b1, 2'b10, 1'b0, BASE + 32'd8, 32'h1122_3344);
    get_rsp(0, wr, err, d, c);
    do_req(0, 1'b1, 2'b00, 1'b0, BASE + 32'd9, 32'hABCD_EF80);
    get_rsp(0, wr, err, d, c);
    for (int i = 0; i < 6; i++) begin
      do_req(0, 1'b0, t_op[i], t_sx[i], BASE + t_off[i], 32'h0);
      get_rsp(0, wr, err, d, c);
      n_tests++;
      if (err !== 1'b0 || d !== t_exp[i]) begin
        n_fail++;
        $display("FAIL subword_load[%0d] off=%0d op=%0d sext=%b: err=%b rdata=%h, expected 0 %h",
                 i, t_off[i], t_op[i], t_sx[i], err, d, t_exp[i]);
      end
    end
  endtask

  task automatic test_faults_a();
    logic wr, err; logic [31:0] d; int c;
    logic [31:0] f_off [4] = '{32'd1, 32'd2, 32'd4, 32'(DEPTH * 4)};
    logic [1:0]  f_op  [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    do_req(0, 1'b1, 2'b10, 1'b0, BASE, 32'h0102_0304);
    get_rsp(0, wr, err, d, c);
    do_req(0, 1'b1, 2'b10, 1'b0, BASE + 32'd4, 32'h0506_0708);
    get_rsp(0, wr, err, d, c);
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1'b1, f_op[i], 1'b0, BASE + f_off[i], 32'hFFFF_FFFF);
      get_rsp(0, wr, err, d, c);
      n_tests++;
      if (err !== 1'b1 || d !== 32'h0 || wr !== 1'b1) begin
        n_fail++;
        $display("FAIL fault_store[%0d]: wr=%b err=%b rdata=%h, expected 1 1 00000000", i, wr, err, d);
      end
    end
    n_tests++;
    if (errc(0) !== 16'd4) begin
      n_fail++; $display("FAIL err_count_4: got %0d, expected 4", errc(0));
    end
    do_req(0, 1'b0, 2'b10, 1'b0, BASE, 32'h0);
    get_rsp(0, wr, err, d, c);
    n_tests++;
    if (err !== 1'b0 || d !== 32'h0102_0304) begin
      n_fail++; $display("FAIL fault_no_write_w0: err=%b rdata=%h, expected 0 01020304", err, d);
    end
    do_req(0, 1'b0, 2'b10, 1'b0, BASE + 32'd4, 32'h0);
    get_rsp(0, wr, err, d, c);
    n_tests++;
    if (err !== 1'b0 || d !== 32'h0506_0708) begin
      n_fail++; $display("FAIL fault_no_write_w1: err=%b rdata=%h, expected 0 05060708", err, d);
    end
    do_req(0, 1'b0, 2'b10, 1'b0, BASE - 32'd4, 32'h0);
    get_rsp(0, wr, err, d, c);
    n_tests++;
    if (err !== 1'b1 || d !== 32'h0 || wr !== 1'b0 || errc(0) !== 16'd5) begin
      n_fail++;
      $display("FAIL fault_below_base: err=%b rdata=%h wr=%b cnt=%0d, expected 1 00000000 0 5", err, d, wr, errc(0));
    end
    do_req(0, 1'b1, 2'b10, 1'b0, BASE + 32'(DEPTH * 4 - 4), 32'h5A5A_5A5A);
    get_rsp(0, wr, err, d, c);
    do_req(0, 1'b0, 2'b10, 1'b0, BASE + 32'(DEPTH * 4 - 4), 32'h0);
    get_rsp(0, wr, err, d, c);
    n_tests++;
    if (err !== 1'b0 || d !== 32'h5A5A_5A5A) begin
      n_fail++; $display("FAIL last_word: err=%b rdata=%h, expected 0 5a5a5a5a", err, d);
    end
  endtask

  task automatic test_saturate_a();
    logic wr, err; logic [31:0] d; int c;
    for (int i = 0; i < 9; i++) begin
      do_req(0, 1'b0, 2'b11, 1'b0, BASE, 32'h0);
      get_rsp(0, wr, err, d, c);
    end
    n_tests++;
    if (errc(0) !== 16'd14) begin
      n_fail++; $display("FAIL err_count_14: got %0d, expected 14", errc(0));
    end
    for (int i = 0; i < 3; i++) begin
      do_req(0, 1'b0, 2'b11, 1'b0, BASE, 32'h0);
      get_rsp(0, wr, err, d, c);
      n_tests++;
      if (errc(0) !== 16'd15) begin
        n_fail++; $display("FAIL err_saturate[%0d]: got %0d, expected 15", i, errc(0));
      end
    end
  endtask

  task automatic test_random(input int d, input int n);
    exp_t q[$];
    exp_t e;
    int fill = 0;
    logic [15:0] ecnt = '0;
    logic [15:0] emax;
    logic exp_v, stall, acc, f;
    logic [31:0] off;
    emax = (d != 0) ? 16'hFFFF : 16'h000F;
    @(negedge clk); rst = 1'b1; req_valid[d] = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < n + 24; c++) begin
      @(negedge clk);
      if (c >= n) begin
        req_valid[d] = 1'b0; rsp_ready[d] = 1'b1;
      end else begin
        if (fill < DEPTH) begin
          req_valid[d] = 1'b1; req_we[d] = 1'b1; req_op[d] = 2'b10;
          req_addr[d] = BASE + 32'(fill * 4);
        end else begin
          req_valid[d] = ($urandom_range(0, 9) < 7);
          req_we[d] = 1'($urandom_range(0, 1));
          req_op[d] = 2'($urandom_range(0, 3));
          req_addr[d] = ($urandom_range(0, 15) == 0) ? $urandom : BASE + $urandom_range(0, DEPTH * 4 - 1);
        end
        req_wdata[d] = $urandom;
        req_sext[d] = 1'($urandom_range(0, 1));
        rsp_ready[d] = ($urandom_range(0, 3) != 0);
      end
      #1;
      exp_v = (q.size() > 0) && (q[0].due == 0);
      stall = exp_v && !rsp_ready[d];
      n_tests++;
      if (rsp_valid[d] !== exp_v) begin
        n_fail++; $display("FAIL rnd_valid dut=%0d cyc=%0d: got %b, expected %b", d, c, rsp_valid[d], exp_v);
      end
      if (exp_v) begin
        n_tests++;
        if (rsp_wr[d] !== q[0].wr || rsp_err[d] !== q[0].err || rsp_rdata[d] !== q[0].data) begin
          n_fail++;
          $display("FAIL rnd_rsp dut=%0d cyc=%0d: wr=%b err=%b rdata=%h, expected %b %b %h",
                   d, c, rsp_wr[d], rsp_err[d], rsp_rdata[d], q[0].wr, q[0].err, q[0].data);
        end
      end
      n_tests++;
      if (req_ready[d] !== !stall) begin
        n_fail++; $display("FAIL rnd_ready dut=%0d cyc=%0d: got %b, expected %b", d, c, req_ready[d], !stall);
      end
      n_tests++;
      if (errc(d) !== ecnt) begin
        n_fail++; $display("FAIL rnd_errcnt dut=%0d cyc=%0d: got %0d, expected %0d", d, c, errc(d), ecnt);
      end
      acc = req_valid[d] && !stall;
      if (exp_v && rsp_ready[d]) void'(q.pop_front());
      if (!stall) foreach (q[i]) if (q[i].due > 0) q[i].due--;
      if (acc) begin
        off = req_addr[d] - BASE;
        f = model_fault(req_op[d], off);
        e.due = lat(d) - 1; e.wr = req_we[d]; e.err = f; e.data = '0;
        if (!f && !req_we[d]) e.data = model_load(int'(off), req_op[d], req_sext[d]);
        if (!f && req_we[d]) model_store(int'(off), req_op[d], req_wdata[d]);
        if (f && ecnt != emax) ecnt++;
        if (fill < DEPTH) fill++;
        q.push_back(e);
      end
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL rnd_drain dut=%0d: %0d responses outstanding, expected 0", d, q.size());
    end
  endtask

  task automatic test_stall_b();
    logic wr, err; logic [31:0] d; int c;
    logic [31:0] expv [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    logic [31:0] got[$];
    logic [31:0] hold = '0;
    int acc = 0, stall_cycles = 0;
    bit bad_ready = 0, bad_hold = 0, stalled_prev = 0, extra = 0;
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b1, 2'b10, 1'b0, BASE + 32'h40 + 32'(i * 4), expv[i]);
      get_rsp(1, wr, err, d, c);
    end
    for (int k = 0; k < 30 && got.size() < 4; k++) begin
      @(negedge clk);
      req_valid[1] = (acc < 4); req_we[1] = 1'b0; req_op[1] = 2'b10; req_sext[1] = 1'b0;
      req_addr[1] = BASE + 32'h40 + 32'(acc * 4);
      rsp_ready[1] = !(k >= 3 && k < 8);
      #1;
      if (rsp_valid[1] && !rsp_ready[1]) begin
        stall_cycles++;
        if (req_ready[1]) bad_ready = 1;
        if (stalled_prev && rsp_rdata[1] !== hold) bad_hold = 1;
        hold = rsp_rdata[1];
        stalled_prev = 1;
      end else begin
        stalled_prev = 0;
      end
      if (req_valid[1] && req_ready[1]) acc++;
      if (rsp_valid[1] && rsp_ready[1]) got.push_back(rsp_rdata[1]);
    end
    @(negedge clk); req_valid[1] = 1'b0; rsp_ready[1] = 1'b1;
    repeat (5) begin @(negedge clk); #1; if (rsp_valid[1]) extra = 1; end
    n_tests++;
    if (stall_cycles != 5 || bad_ready || bad_hold) begin
      n_fail++;
      $display("FAIL stall_hold: stall_cycles=%0d ready_during_stall=%b data_moved=%b, expected 5 0 0",
               stall_cycles, bad_ready, bad_hold);
    end
    n_tests++;
    if (got.size() != 4 || extra) begin
      n_fail++; $display("FAIL stall_count: got %0d responses extra=%b, expected 4 0", got.size(), extra);
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== expv[i]) begin
        n_fail++; $display("FAIL stall_order[%0d]: rdata=%h, expected %h", i, got[i], expv[i]);
      end
    end
  endtask

  task automatic test_reset_flight_b();
    logic wr, err; logic [31:0] d; int c;
    bit bad = 0;
    do_req(1, 1'b1, 2'b10, 1'b0, BASE + 32'h80, 32'hCAFE_F00D);
    get_rsp(1, wr, err, d, c);
    do_req(1, 1'b0, 2'b11, 1'b0, BASE, 32'h0);
    get_rsp(1, wr, err, d, c);
    do_req(1, 1'b0, 2'b10, 1'b0, BASE + 32'h80, 32'h0);
    do_req(1, 1'b0, 2'b10, 1'b0, BASE + 32'h84, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (rsp_valid[1] !== 1'b0 || errc(1) !== 16'h0 || req_ready[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flight: vld=%b cnt=%0d rdy=%b, expected 0 0 0", rsp_valid[1], errc(1), req_ready[1]);
    end
    @(negedge clk); rst = 1'b0;
    repeat (6) begin @(negedge clk); #1; if (rsp_valid[1]) bad = 1; end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL reset_discard: rsp_valid seen 1 after reset, expected 0");
    end
    do_req(1, 1'b0, 2'b10, 1'b0, BASE + 32'h80, 32'h0);
    get_rsp(1, wr, err, d, c);
    n_tests++;
    if (d !== 32'hCAFE_F00D || err !== 1'b0 || c !== 3) begin
      n_fail++;
      $display("FAIL mem_retained: rdata=%h err=%b lat=%0d, expected cafef00d 0 3", d, err, c);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_sext = '0; req_op = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 2'b11;
    test_reset();
    test_word_a();
    test_byte_a();
    test_faults_a();
    test_saturate_a();
    test_random(0, 300);
    test_random(1, 300);
    test_stall_b();
    test_reset_flight_b();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
